// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, steers a synchronous-read imem
// and presents a valid/ready instruction stream with redirect, halt and stall accounting.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_stall,
    input  logic [15:0] imem_instr,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    // state | meaning
    // RUN    | issuing one fetch per advancing cycle
    // HALTED | no new fetches; left only through a redirect
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        advance;

    assign advance    = !resp_valid_q || out_ready || redirect_valid;
    assign imem_stall = !advance;
    assign imem_addr  = fetch_pc_q;
    assign out_valid  = resp_valid_q && !redirect_valid;
    assign out_pc     = resp_pc_q;
    assign out_instr  = imem_instr;
    assign halted     = (state_q == ST_HALTED);
    assign stall_cnt  = stall_cnt_q;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;

        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        if (redirect_valid) begin
            // the word imem loads this cycle belongs to the old path
            fetch_pc_d   = redirect_pc;
            resp_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (halt_req) begin
                state_d = ST_HALTED;
            end
            if (advance) begin
                resp_pc_d    = fetch_pc_q;
                resp_valid_d = 1'b1;
                if (!halt_req) begin
                    fetch_pc_d = fetch_pc_q + 16'd1;
                end
            end
        end else if (advance) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= 16'h0000;
            resp_valid_q <= 1'b0;
            state_q      <= ST_RUN;
            stall_cnt_q  <= 16'h0000;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (RESET_PC 0x0010 and 0xFFFE) share stimulus;
// a stream-level model predicts each instance's outputs every cycle.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;

    logic [15:0] imem_addr [2];
    logic        imem_stall[2];
    logic [15:0] imem_instr[2];
    logic        out_valid [2];
    logic [15:0] out_instr [2];
    logic [15:0] out_pc    [2];
    logic        halted    [2];
    logic [15:0] stall_cnt [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(16'h0010)) u_dut_a (
        .clk(clk), .rst(rst), .imem_addr(imem_addr[0]), .imem_stall(imem_stall[0]),
        .imem_instr(imem_instr[0]), .out_valid(out_valid[0]), .out_instr(out_instr[0]),
        .out_pc(out_pc[0]), .out_ready(out_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted[0]),
        .stall_cnt(stall_cnt[0])
    );

    fetch_ctrl #(.RESET_PC(16'hFFFE)) u_dut_b (
        .clk(clk), .rst(rst), .imem_addr(imem_addr[1]), .imem_stall(imem_stall[1]),
        .imem_instr(imem_instr[1]), .out_valid(out_valid[1]), .out_instr(out_instr[1]),
        .out_pc(out_pc[1]), .out_ready(out_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .halted(halted[1]),
        .stall_cnt(stall_cnt[1])
    );

    // instruction memory contents: a byte swap plus a pattern keeps neighbouring words distinct
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    initial begin
        imem_instr[0] = 16'h0000;
        imem_instr[1] = 16'h0000;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!imem_stall[k]) imem_instr[k] <= mem_word(imem_addr[k]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: m_have = a word is waiting for decode (m_word_pc), m_next = next
    // address to request, m_stop = fetching halted, m_cnt = back-pressure cycles seen.
    logic        m_have[2];
    logic [15:0] m_word_pc[2];
    logic [15:0] m_next[2];
    logic        m_stop[2];
    int unsigned m_cnt[2];
    logic [15:0] m_reset_pc[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_have[k] = 1'b0;
            m_word_pc[k] = 16'h0000;
            m_next[k] = m_reset_pc[k];
            m_stop[k] = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_check();
        logic presenting, blocked;
        for (int k = 0; k < 2; k++) begin
            presenting = m_have[k] && !redirect_valid;
            blocked = presenting && !out_ready;
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(presenting));
            chk($sformatf("imem_stall[%0d]", k), 32'(imem_stall[k]), 32'(blocked));
            chk($sformatf("imem_addr[%0d]", k), 32'(imem_addr[k]), 32'(m_next[k]));
            chk($sformatf("halted[%0d]", k), 32'(halted[k]), 32'(m_stop[k]));
            chk($sformatf("stall_cnt[%0d]", k), 32'(stall_cnt[k]), m_cnt[k] > 32'hFFFF ? 32'hFFFF : m_cnt[k]);
            if (presenting) begin
                chk($sformatf("out_pc[%0d]", k), 32'(out_pc[k]), 32'(m_word_pc[k]));
                chk($sformatf("out_instr[%0d]", k), 32'(out_instr[k]), 32'(mem_word(m_word_pc[k])));
            end
        end
    endtask

    task automatic model_advance();
        logic presenting, taken;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            presenting = m_have[k] && !redirect_valid;
            taken = !presenting || out_ready;
            if (presenting && !out_ready) m_cnt[k]++;
            if (redirect_valid) begin
                m_have[k] = 1'b0;
                m_next[k] = redirect_pc;
                m_stop[k] = 1'b0;
            end else if (!taken) begin
                if (halt_req) m_stop[k] = 1'b1;
            end else if (m_stop[k]) begin
                m_have[k] = 1'b0;
            end else begin
                m_have[k] = 1'b1;
                m_word_pc[k] = m_next[k];
                if (halt_req) m_stop[k] = 1'b1;
                else m_next[k] = m_next[k] + 16'd1;
            end
        end
    endtask

    // one clock cycle: drive, check combinational/registered outputs, predict the edge
    task automatic step(input logic r, input logic rdy, input logic rv,
                        input logic [15:0] rpc, input logic hr, input bit do_check);
        rst = r;
        out_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        halt_req = hr;
        #1;
        if (do_check) model_check();
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        m_reset_pc[0] = 16'h0010;
        m_reset_pc[1] = 16'hFFFE;
        model_reset();
        @(negedge clk);
        step(1, 1, 0, 16'h0, 0, 0);
        step(1, 1, 0, 16'h0, 0, 1);
        chk("reset_addr_a", 32'(imem_addr[0]), 32'h0010);

        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("first_pc_a", 32'(out_pc[0]), 32'h0010);
        chk("first_pc_b", 32'(out_pc[1]), 32'hFFFE);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("second_pc_b", 32'(out_pc[1]), 32'hFFFF);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("wrap_pc_b", 32'(out_pc[1]), 32'h0000);
        chk("third_pc_a", 32'(out_pc[0]), 32'h0012);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0, 1);
        #1 chk("stall_cnt_3", 32'(stall_cnt[0]), 32'd3);
        chk("held_pc_a", 32'(out_pc[0]), 32'h0012);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("after_stall_pc", 32'(out_pc[0]), 32'h0013);

        step(0, 1, 1, 16'h0200, 0, 1);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("redirect_target", 32'(out_pc[0]), 32'h0200);
        chk("redirect_valid_out", 32'(out_valid[0]), 32'd1);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("redirect_next", 32'(out_pc[0]), 32'h0201);

        step(0, 1, 1, 16'h0020, 0, 1);
        step(0, 1, 0, 16'h0, 0, 1);
        step(0, 1, 0, 16'h0, 1, 1);
        #1 chk("halt_last_pc", 32'(out_pc[0]), 32'h0021);
        chk("halted_set", 32'(halted[0]), 32'd1);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("halt_drained", 32'(out_valid[0]), 32'd0);
        step(0, 1, 0, 16'h0, 1, 1);
        step(0, 1, 1, 16'h0040, 0, 1);
        #1 chk("halt_exit", 32'(halted[0]), 32'd0);
        step(0, 1, 0, 16'h0, 0, 1);
        #1 chk("halt_exit_pc", 32'(out_pc[0]), 32'h0040);

        step(0, 0, 0, 16'h0, 0, 1);
        step(0, 0, 0, 16'h0, 0, 1);
        step(1, 0, 0, 16'h0, 0, 1);
        #1 chk("rst_cnt_clear", 32'(stall_cnt[0]), 32'd0);
        chk("rst_addr_b", 32'(imem_addr[1]), 32'hFFFE);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0),
                 16'($urandom()),
                 ($urandom_range(0, 29) == 0),
                 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
